// File: rtl/if_fetch_queue.sv
// Instruction fetch unit with a small in-order queue of {pc, word} pairs.
// A fetch reads the instruction memory combinationally and pushes the word
// into the queue in the same cycle, so a fetched instruction is offered to
// decode one cycle later. A redirect flushes the queue and restarts fetch
// at the new (word-aligned) PC on the following cycle.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_rena,
  output logic [10:0]              imem_addr,
  input  logic [31:0]              imem_data,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Control state
  logic [31:0]      r_pc;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Queue storage (no reset: contents are meaningless while count is zero)
  logic [31:0]      r_q_pc   [DEPTH];
  logic [31:0]      r_q_word [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_fetch;
  logic [31:0]      w_redirect_pc;
  logic [31:0]      w_pc_next;

  // Word-aligns a redirect target by clearing the byte-offset bits.
  function automatic logic [31:0] align_word(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CNT_FULL);
  assign w_pop         = ~w_empty & inst_ready;
  assign w_redirect_pc = align_word(redirect_pc);
  assign w_pc_next     = pc_plus4(r_pc);

  // A slot is free if the queue is not full or the head leaves this cycle.
  // Reset and redirect both cancel the fetch, so no push happens then.
  assign w_fetch = rst_n & fetch_en & ~redirect_valid & (~w_full | w_pop);

  assign imem_rena  = w_fetch;
  assign imem_addr  = r_pc[12:2];

  assign inst_valid = ~w_empty;
  assign inst_data  = r_q_word[r_rd_ptr];
  assign inst_pc    = r_q_pc[r_rd_ptr];
  assign q_count    = r_count;

  // Fetch PC, pointers and occupancy; reset beats redirect, redirect beats fetch/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_pc     <= w_redirect_pc;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fetch) begin
        r_pc     <= w_pc_next;
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_fetch, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Push the fetched word and its PC at the write pointer.
  always_ff @(posedge clk) begin
    if (w_fetch) begin
      r_q_pc[r_wr_ptr]   <= r_pc;
      r_q_word[r_wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: stimulus queues expected {pc, word}
// pairs; a monitor compares them against every instruction decode accepts.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_rena;
  logic [10:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [2:0]  q_count;

  int n_st_tot  = 0;
  int n_st_pass = 0;
  int n_sb_tot  = 0;
  int n_sb_pass = 0;

  logic [63:0] exp_q[$];

  if_fetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_rena      (imem_rena),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .q_count        (q_count)
  );

  // Instruction memory: word at address a is 0xC0DE0000 | a.
  assign imem_data = 32'hC0DE_0000 | {21'd0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted instruction must match the next expected pair.
  always @(negedge clk) begin
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      n_sb_tot = n_sb_tot + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got pc=%08h word=%08h, required none", inst_pc, inst_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({inst_pc, inst_data} === e)
          n_sb_pass = n_sb_pass + 1;
        else
          $display("FAIL sb_inst: got pc=%08h word=%08h, required pc=%08h word=%08h",
                   inst_pc, inst_data, e[63:32], e[31:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_st_tot = n_st_tot + 1;
    if (act === exp) n_st_pass = n_st_pass + 1;
    else $display("FAIL %s: got %08h, required %08h", name, act, exp);
  endtask

  task automatic expect_inst(input logic [31:0] pc, input logic [31:0] word);
    exp_q.push_back({pc, word});
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic rn, input logic fe, input logic rv,
                     input logic [31:0] rp, input logic rdy);
    @(posedge clk);
    #1;
    rst_n          = rn;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rp;
    inst_ready     = rdy;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required normal end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; inst_ready = 1'b0;

    // Reset
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h000);
    cyc(0, 1, 0, 0, 0);
    chk("rst_rena_gated", 32'(imem_rena), 0);

    // Streaming, one instruction per cycle
    for (int k = 0; k < 6; k++) expect_inst(32'h0040_0000 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
    cyc(1, 1, 0, 0, 1);
    chk("c0_rena", 32'(imem_rena), 1);
    chk("c0_addr", 32'(imem_addr), 0);
    chk("c0_valid", 32'(inst_valid), 0);
    for (int k = 1; k < 6; k++) begin
      cyc(1, 1, 0, 0, 1);
      chk("stream_addr", 32'(imem_addr), 32'(k));
      chk("stream_valid", 32'(inst_valid), 1);
      chk("stream_count", 32'(q_count), 1);
    end
    cyc(1, 0, 0, 0, 1);
    chk("fe0_rena", 32'(imem_rena), 0);
    chk("fe0_valid", 32'(inst_valid), 1);
    cyc(1, 0, 0, 0, 1);
    chk("drain_count", 32'(q_count), 0);
    chk("drain_valid", 32'(inst_valid), 0);

    // Fill to full, stall, then pop+refill
    for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, 0, 0, 0);
      chk("full_count", 32'(q_count), 4);
      chk("full_rena", 32'(imem_rena), 0);
      chk("full_addr", 32'(imem_addr), 32'h00A);
    end
    expect_inst(32'h0040_0018, 32'hC0DE_0006);
    cyc(1, 1, 0, 0, 1);
    chk("fullpop_rena", 32'(imem_rena), 1);
    chk("fullpop_count", 32'(q_count), 4);
    cyc(1, 1, 0, 0, 0);
    chk("refill_count", 32'(q_count), 4);
    chk("refill_addr", 32'(imem_addr), 32'h00B);
    chk("refill_rena", 32'(imem_rena), 0);

    // Redirect with pop and full in the same cycle
    expect_inst(32'h0040_001C, 32'hC0DE_0007);
    cyc(1, 1, 1, 32'h0040_0203, 1);
    chk("rdfull_rena", 32'(imem_rena), 0);
    cyc(1, 1, 0, 0, 0);
    chk("rdfull_count", 32'(q_count), 0);
    chk("rdfull_valid", 32'(inst_valid), 0);
    chk("rdfull_addr", 32'(imem_addr), 32'h080);
    chk("rdfull_rena1", 32'(imem_rena), 1);
    cyc(1, 1, 0, 0, 0);
    chk("rdfull_pc", inst_pc, 32'h0040_0200);
    chk("rdfull_data", inst_data, 32'hC0DE_0080);
    chk("rdfull_count1", 32'(q_count), 1);
    cyc(1, 1, 0, 0, 0);

    // Redirect with three entries queued
    cyc(1, 1, 1, 32'h0040_0103, 0);
    chk("rd3_count_before", 32'(q_count), 3);
    cyc(1, 1, 0, 0, 0);
    chk("rd3_count", 32'(q_count), 0);
    chk("rd3_valid", 32'(inst_valid), 0);
    chk("rd3_addr", 32'(imem_addr), 32'h040);
    expect_inst(32'h0040_0100, 32'hC0DE_0040);
    expect_inst(32'h0040_0104, 32'hC0DE_0041);
    cyc(1, 1, 0, 0, 1);
    chk("rd3_pc", inst_pc, 32'h0040_0100);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 0);

    // Reset overrides a simultaneous redirect with two entries queued
    cyc(1, 0, 0, 0, 0);
    chk("pre_rst_count", 32'(q_count), 2);
    cyc(0, 1, 1, 32'h1234_5678, 0);
    chk("midrst_rena", 32'(imem_rena), 0);
    cyc(1, 0, 0, 0, 0);
    chk("midrst_count", 32'(q_count), 0);
    chk("midrst_valid", 32'(inst_valid), 0);
    chk("midrst_addr", 32'(imem_addr), 32'h000);

    // PC wrap at the top of the address space
    cyc(1, 1, 1, 32'hFFFF_FFFF, 1);
    expect_inst(32'hFFFF_FFFC, 32'hC0DE_07FF);
    expect_inst(32'h0000_0000, 32'hC0DE_0000);
    cyc(1, 1, 0, 0, 1);
    chk("wrap_addr_top", 32'(imem_addr), 32'h7FF);
    chk("wrap_rena", 32'(imem_rena), 1);
    chk("wrap_valid0", 32'(inst_valid), 0);
    cyc(1, 1, 0, 0, 1);
    chk("wrap_addr_zero", 32'(imem_addr), 32'h000);
    chk("wrap_pc_top", inst_pc, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 1);
    chk("wrap_pc_zero", inst_pc, 32'h0000_0000);
    cyc(1, 0, 0, 0, 0);
    chk("end_count", 32'(q_count), 0);
    cyc(1, 0, 0, 0, 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_st_pass + n_sb_pass, n_st_tot + n_sb_tot);
    $finish;
  end

endmodule
